// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// controller states and the iteration-counter width.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned CNT_W = cnt_width(XLEN);

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for
// divide. Purely combinational; the caller registers acc_o.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}.
    add_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i & {WIDTH{acc_i[0]}}};

    // Divide: acc = {partial remainder, dividend bits / quotient bits}.
    rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opnd_i};

    if (is_div_i) begin
      if (!diff[WIDTH]) begin
        acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {add_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers, with a
// start/busy/done handshake for the EX-stage hazard logic.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned      CW        = cnt_width(WIDTH);
  localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;

  op_e                op_in;
  logic               in_signed, in_is_div, in_neg_a, in_neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op_in     = op_e'(op);
  assign in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign in_is_div = (op_in == OP_DIV)  || (op_in == OP_DIVU);
  assign in_neg_a  = in_signed & a[WIDTH-1];
  assign in_neg_b  = in_signed & b[WIDTH-1];
  assign mag_a     = in_neg_a ? -a : a;
  assign mag_b     = in_neg_b ? -b : b;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .is_div_i (is_div_q),
    .acc_o    (step_acc)
  );

  // Sign correction; unsigned ops latch both sign bits as 0.
  assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
  assign quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    // NOTE: every signal is given its hold value first so no path through the
    // case below leaves one unassigned and infers a latch.
    state_d  = state_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;

    unique case (state_q)
      IDLE: begin
        if (wr_hi) hi_d = wr_data;
        if (wr_lo) lo_d = wr_data;
        if (start) begin
          is_div_d = in_is_div;
          neg_a_d  = in_neg_a;
          neg_b_d  = in_neg_b;
          // Divide keeps the dividend in the accumulator; multiply keeps the multiplier.
          acc_d    = in_is_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
          opnd_d   = in_is_div ? mag_b : mag_a;
          count_d  = '0;
          dbz_d    = 1'b0;
          state_d  = RUN;
        end
      end

      RUN: begin
        acc_d   = step_acc;
        count_d = count_q + 1'b1;
        if (count_q == LAST_STEP) state_d = FIX;
      end

      FIX: begin
        if (is_div_q) begin
          // With a zero divisor the restoring loop leaves |a| as the remainder,
          // so the usual remainder correction already reproduces the original a.
          hi_d = rem_fix;
          lo_d = (opnd_q == '0) ? {WIDTH{1'b1}} : quo_fix;
          if (opnd_q == '0) dbz_d = 1'b1;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // NOTE: the datapath registers are not reset; they are always reloaded on an
  // accepted start before the controller reads them.
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    opnd_q   <= opnd_d;
    is_div_q <= is_div_d;
    neg_a_q  <= neg_a_d;
    neg_b_q  <= neg_b_d;
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
